uart_tx_device: RTL and testbench

UART_TX_DEVICE -- requirements
Module: uart_tx_device

---
 rtl/uart_tx_device.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_device.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_device.sv
// UART transmitter with a small character FIFO and a registered status word.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_device #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] status,
    output logic                  tx
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   status_q, status_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic baud_end, pop, push, drop, full_now;

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign full_now = (count_q == CNT_W'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only characters already counted last cycle are eligible.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef UART_TX_PARITY_EN
    assign parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
`endif

    // The line is registered from the next state so it changes with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        push     = wr_en && (!full_now || pop);
        drop     = wr_en && full_now && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = drop ? 1'b1 : (rd_en ? 1'b0 : ovf_q);
        status_d    = '0;
        status_d[0] = (state_d != S_IDLE);
        status_d[1] = (count_d == CNT_W'(FIFO_DEPTH));
        status_d[2] = (count_d == '0);
        status_d[3] = ovf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            status_q <= DATA_WIDTH'(4);
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign status = status_q;
    assign tx     = tx_q;
endmodule

// File: tb/tb_uart_tx_device.sv
// Randomised and directed bench for uart_tx_device, checked against a
// queue-based frame-timing model of the transmitter.
module tb_uart_tx_device;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = DW + 3;
`else
  localparam int FRAME = DW + 2;
`endif

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic [DW-1:0] status;
  logic tx;

  always #5 clk = ~clk;

  uart_tx_device #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .status(status), .tx(tx)
  );

  // scoreboard: exp_q holds characters queued but not yet started
  logic [DW-1:0] exp_q[$];
  bit m_in_frame = 0;
  int m_pop_edge = 0;
  logic [DW-1:0] m_cur = '0;
  bit m_ovf = 0;
  int edge_n = 0;
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic bit_at(input int k, input logic [DW-1:0] d);
    int i;
    i = k / CPB;
    if (i == 0) return 1'b0;
    if (i <= DW) return d[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r, input bit rs);
    int sz;
    bit pop;
    bit full;
    bit drop;
    if (rs) begin
      exp_q.delete();
      m_in_frame = 0;
      m_ovf = 0;
      return;
    end
    sz = exp_q.size();
    pop = !m_in_frame && (sz > 0);
    full = (sz == DEPTH);
    if (m_in_frame && edge_n == m_pop_edge + FRAME * CPB) m_in_frame = 0;
    if (pop) begin
      m_cur = exp_q.pop_front();
      m_in_frame = 1;
      m_pop_edge = edge_n;
    end
    drop = w && full && !pop;
    if (w && !drop) exp_q.push_back(d);
    if (drop) m_ovf = 1;
    else if (r) m_ovf = 0;
  endtask

  function automatic logic [DW-1:0] exp_status();
    logic [DW-1:0] s;
    s = '0;
    s[0] = m_in_frame;
    s[1] = (exp_q.size() == DEPTH);
    s[2] = (exp_q.size() == 0);
    s[3] = m_ovf;
    return s;
  endfunction

  // driver task: one clock with the given inputs, then compare against the model
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit rs);
    logic exp_tx;
    wr_en = w;
    wr_data = d;
    rd_en = r;
    rst = rs;
    @(posedge clk);
    edge_n++;
    model_edge(w, d, r, rs);
    #1;
    exp_tx = m_in_frame ? bit_at(edge_n - m_pop_edge, m_cur) : 1'b1;
    check("tx", tx, exp_tx);
    check("status", status, exp_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  logic line_exp[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int kk;
    int bi;
    int guard;

    // reset
    step(0, '0, 0, 1);
    step(1, 8'hFF, 0, 1);
    check("rst_status", status, 32'h04);
    check("rst_tx", tx, 1);
    idle(3);

    // single 0xA5 frame: latency and line pattern
    step(1, 8'hA5, 0, 0);
    check("lat_hi", tx, 1);
    step(0, '0, 0, 0);
    check("lat_lo", tx, 0);
    check("busy", status[0], 1);
    for (int k = 0; k < FRAME * CPB + 2; k++) begin
      step(0, '0, 0, 0);
      kk = edge_n - m_pop_edge;
      if (kk % CPB == CPB / 2) begin
        bi = kk / CPB;
        if (bi < 9) check("a5_bit", tx, line_exp[bi]);
        else if (bi == FRAME - 1) check("a5_stop", tx, 1);
      end
    end
    check("a5_after", status, 32'h04);

    // three back-to-back characters
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    idle(3 * (FRAME * CPB + 1) + 4);
    check("b2b_after", status, 32'h04);

    // overflow: five writes while a frame is in flight
    step(1, 8'h11, 0, 0);
    idle(3);
    for (int i = 0; i < 5; i++) step(1, DW'(8'h20 + i), 0, 0);
    check("ovf_set", status[3], 1);
    check("ovf_full", status[1], 1);
    step(0, '0, 1, 0);
    check("ovf_clr", status[3], 0);
    check("ovf_clr_full", status[1], 1);
    check("ovf_clr_busy", status[0], 1);
    idle(5 * (FRAME * CPB + 1) + 4);

    // write while full on the pop cycle
    step(1, 8'h31, 0, 0);
    for (int i = 0; i < 4; i++) step(1, DW'(8'h40 + i), 0, 0);
    check("pop_full", status[1], 1);
    guard = 0;
    while (m_in_frame && guard < 2 * FRAME * CPB) begin
      step(0, '0, 0, 0);
      guard++;
    end
    check("pop_wait_bound", guard < 2 * FRAME * CPB, 1);
    step(1, 8'h99, 0, 0);
    check("pop_wr_full", status[1], 1);
    check("pop_wr_ovf", status[3], 0);
    idle(5 * (FRAME * CPB + 1) + 4);

    // reset in the middle of data bit 3 with two queued
    step(1, 8'h5A, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(1, 8'h77, 0, 0);
    guard = 0;
    while ((edge_n - m_pop_edge) != 4 * CPB + 5 && guard < 200) begin
      step(0, '0, 0, 0);
      guard++;
    end
    check("mid_wait_bound", guard < 200, 1);
    step(1, 8'hEE, 0, 1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_status", status, 32'h04);
    idle(2 * FRAME * CPB);
    check("mid_rst_quiet", status, 32'h04);

`ifdef UART_TX_PARITY_EN
    step(1, 8'h07, 0, 0);
    step(1, 8'h03, 0, 0);
    idle(2 * (FRAME * CPB + 1) + 4);
`endif

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 29) == 0, DW'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
